// File: rtl/fifo_wr_arb_pkg.sv
// fifo_wr_arb_pkg: definitions shared by the FIFO write arbiter and its round-robin picker.
//   - arb_state_e         : arbiter FSM states (IDLE, BURST)
//   - DefaultDsize/Nreq/MaxBurst : default parameter values for fifo_wr_arb
//   - CntW / StatW        : burst counter width and per-requester statistics counter width
package fifo_wr_arb_pkg;

    localparam int unsigned DefaultDsize    = 8;
    localparam int unsigned DefaultNreq     = 4;
    localparam int unsigned DefaultMaxBurst = 8;

    // MAX_BURST is at most 255, so 8 bits always hold the in-grant word count.
    localparam int unsigned CntW  = 8;
    localparam int unsigned StatW = 16;

    typedef enum logic {
        IDLE,
        BURST
    } arb_state_e;

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Returns a one-hot select of the first set request bit at or above rr_ptr, wrapping
// past the top requester back to 0. All-zero when no request is set.
// Ports:
//   req    [NREQ-1:0] : request vector
//   rr_ptr [PtrW-1:0] : index the search starts from
//   sel    [NREQ-1:0] : one-hot winner
module rr_pick
    import fifo_wr_arb_pkg::*;
#(
    parameter int unsigned NREQ = DefaultNreq,
    localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PtrW-1:0] rr_ptr,
    output logic [NREQ-1:0] sel
);

    logic            found;
    logic [PtrW-1:0] idx;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = PtrW'((32'(rr_ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                sel[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin burst arbiter feeding the write side of a FIFO.
// One requester owns the FIFO write port per grant; a grant ends on a word marked last,
// after MAX_BURST words, or when the owner drops its request. One idle arbitration cycle
// separates consecutive grants. Everything runs in the FIFO write-clock domain.
// Optional feature: define FIFO_WR_ARB_STATS_EN to add the wr_count port holding a
// saturating 16-bit accepted-word count per requester.
// Ports:
//   wclk, wrst  : clock, synchronous active-high reset
//   req         : per-requester word valid
//   req_data    : requester i data in [i*DSIZE +: DSIZE]
//   req_last    : current word ends the requester's burst
//   ack         : word accepted from requester i this cycle
//   gnt         : one-hot current owner (registered), zero when idle
//   wfull       : FIFO full
//   winc, wdata : FIFO write enable and data
//   wr_count    : (FIFO_WR_ARB_STATS_EN only) per-requester ack counts, 16 bits each
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter int unsigned DSIZE     = DefaultDsize,
    parameter int unsigned NREQ      = DefaultNreq,
    parameter int unsigned MAX_BURST = DefaultMaxBurst,
    localparam int unsigned PtrW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DSIZE-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       gnt,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [NREQ*StatW-1:0] wr_count
`endif
);

    arb_state_e      state;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] sel;
    logic [CntW-1:0] cnt_q;
    logic [PtrW-1:0] rr_ptr_q;
    logic [PtrW-1:0] owner;
    logic [PtrW-1:0] ptr_next;
    logic            owner_req;
    logic            owner_last;
    logic            burst_done;

    rr_pick #(
        .NREQ(NREQ)
    ) u_rr_pick (
        .req   (req),
        .rr_ptr(rr_ptr_q),
        .sel   (sel)
    );

    always_comb begin
        owner = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) owner = PtrW'(i);
        end
    end

    assign owner_req  = |(gnt_q & req);
    assign owner_last = |(gnt_q & req_last);
    assign ptr_next   = (owner == PtrW'(NREQ - 1)) ? '0 : owner + 1'b1;
    // Evaluated only on an accepted word: this word is the last one of the grant.
    assign burst_done = owner_last || (cnt_q == CntW'(MAX_BURST - 1));

    // Reset forces the write side quiet even though gnt_q still holds the old owner.
    assign ack  = wrst ? '0 : (gnt_q & req & {NREQ{~wfull}});
    assign winc = |ack;
    assign gnt  = gnt_q;

    always_comb begin
        wdata = '0;
        if (!wrst) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (gnt_q[i]) wdata = req_data[i*DSIZE +: DSIZE];
            end
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state    <= IDLE;
            gnt_q    <= '0;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt_q <= '0;
                    if (|req) begin
                        gnt_q <= sel;
                        state <= BURST;
                    end else begin
                        gnt_q <= '0;
                    end
                end
                BURST: begin
                    // A full FIFO freezes the grant, including an owner that has dropped req.
                    if (!wfull) begin
                        if (owner_req && !burst_done) begin
                            cnt_q <= cnt_q + 1'b1;
                        end else begin
                            // Last word, MAX_BURST reached, or owner went away.
                            gnt_q    <= '0;
                            cnt_q    <= '0;
                            rr_ptr_q <= ptr_next;
                            state    <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_q <= '0;
                    cnt_q <= '0;
                end
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [NREQ*StatW-1:0] stat_q;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            stat_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (ack[i] && (stat_q[i*StatW +: StatW] != {StatW{1'b1}})) begin
                    stat_q[i*StatW +: StatW] <= stat_q[i*StatW +: StatW] + 1'b1;
                end
            end
        end
    end

    assign wr_count = stat_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: self-checking bench for fifo_wr_arb (DSIZE=8, NREQ=4, MAX_BURST=8).
// A grant-level reference model (owner index, words taken, round-robin pointer) predicts
// gnt/ack/winc/wdata each cycle; directed scenarios are followed by a randomized phase.
// Define FIFO_WR_ARB_STATS_EN to also check wr_count, including saturation.
module tb_fifo_wr_arb;

    localparam int unsigned DSIZE     = 8;
    localparam int unsigned NREQ      = 4;
    localparam int unsigned MAX_BURST = 8;

    logic                  wclk = 1'b0;
    logic                  wrst;
    logic [NREQ-1:0]       req;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       ack;
    logic [NREQ-1:0]       gnt;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [NREQ*16-1:0]    wr_count;
`endif

    always #5 wclk = ~wclk;

    fifo_wr_arb #(
        .DSIZE    (DSIZE),
        .NREQ     (NREQ),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .wclk    (wclk),
        .wrst    (wrst),
        .req     (req),
        .req_data(req_data),
        .req_last(req_last),
        .ack     (ack),
        .gnt     (gnt),
        .wfull   (wfull),
        .winc    (winc),
        .wdata   (wdata)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .wr_count(wr_count)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: owner is -1 when nobody holds the grant.
    int owner = -1;
    int words = 0;
    int ptr   = 0;
    int stats [NREQ];
    int acks_total [NREQ];

    // Requester behaviour: rem[i] words still to send, last flag on the final one if use_last.
    int rem [NREQ];
    bit use_last [NREQ];

    // Observations of the DUT for scenario-level checks.
    int winc_cnt;
    int dut_words [NREQ];
    logic [NREQ-1:0] last_gnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic end_grant();
        ptr   = (owner + 1) % NREQ;
        owner = -1;
        words = 0;
    endtask

    // One clock cycle: drive inputs just after the edge, check at negedge, advance model.
    task automatic step(input bit full, input bit rst);
        logic [NREQ-1:0]  r;
        logic [NREQ-1:0]  l;
        logic [NREQ-1:0]  e_gnt;
        logic [NREQ-1:0]  e_ack;
        logic [DSIZE-1:0] e_wdata;
        for (int i = 0; i < NREQ; i++) begin
            r[i] = rem[i] > 0;
            l[i] = use_last[i] && rem[i] == 1;
            req_data[i*DSIZE +: DSIZE] = DSIZE'($urandom);
        end
        req      = r;
        req_last = l;
        wfull    = full;
        wrst     = rst;

        e_gnt   = (owner >= 0) ? (NREQ'(1) << owner) : '0;
        e_ack   = (!rst && owner >= 0 && r[owner] && !full) ? e_gnt : '0;
        e_wdata = (!rst && owner >= 0) ? req_data[owner*DSIZE +: DSIZE] : '0;

        @(negedge wclk);
        check("gnt", gnt, e_gnt);
        check("ack", ack, e_ack);
        check("winc", winc, e_ack != 0);
        check("wdata", wdata, e_wdata);
`ifdef FIFO_WR_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++) check("wr_count", wr_count[i*16 +: 16], stats[i]);
`endif
        winc_cnt += int'(winc);
        for (int i = 0; i < NREQ; i++) dut_words[i] += int'(winc && gnt[i]);
        last_gnt = gnt;

        if (rst) begin
            owner = -1;
            words = 0;
            ptr   = 0;
            for (int i = 0; i < NREQ; i++) stats[i] = 0;
        end else if (owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                if (owner < 0 && r[(ptr + k) % NREQ]) begin
                    owner = (ptr + k) % NREQ;
                    words = 0;
                end
            end
        end else if (!full) begin
            if (r[owner]) begin
                words++;
                rem[owner]--;
                acks_total[owner]++;
                if (stats[owner] < 65535) stats[owner]++;
                if (l[owner] || words == MAX_BURST) end_grant();
            end else begin
                end_grant();
            end
        end

        @(posedge wclk);
        #1;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) begin
            rem[i]      = 0;
            use_last[i] = 1'b0;
        end
    endtask

    task automatic clear_counts();
        winc_cnt = 0;
        for (int i = 0; i < NREQ; i++) dut_words[i] = 0;
    endtask

    int n;

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            stats[i]      = 0;
            acks_total[i] = 0;
        end
        clear_reqs();
        clear_counts();
        wrst     = 1'b1;
        wfull    = 1'b0;
        req      = '0;
        req_last = '0;
        req_data = '0;
        @(posedge wclk);
        #1;

        // Reset state, then a quiet idle cycle.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);

        // Requester 0 alone: three words, the third marked last.
        clear_counts();
        rem[0] = 3;
        use_last[0] = 1'b1;
        repeat (8) step(1'b0, 1'b0);
        check("single_burst_words", winc_cnt, 3);
        check("single_burst_gnt_dropped", last_gnt, 0);
        // Pointer now at 1: with 0 and 1 both requesting, 1 must win.
        rem[0] = 1;
        rem[1] = 1;
        use_last[1] = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("rr_ptr_after_burst", last_gnt, 4'b0010);
        repeat (6) step(1'b0, 1'b0);
        clear_reqs();

        // All four requesting forever: 5 grants of 8 words in 45 cycles from reset.
        step(1'b0, 1'b1);
        for (int i = 0; i < NREQ; i++) rem[i] = 1000;
        clear_counts();
        repeat (45) step(1'b0, 1'b0);
        check("rr_all_words", winc_cnt, 40);
        for (int i = 1; i < NREQ; i++) check("rr_all_per_req", dut_words[i], 8);
        check("rr_all_req0", dut_words[0], 16);

        // FIFO full for 5 cycles in the middle of requester 2's burst.
        n = 0;
        while (!(owner == 2 && words == 0) && n < 40) begin
            step(1'b0, 1'b0);
            n++;
        end
        clear_counts();
        n = 0;
        while (!(owner == 2 && words == 3) && n < 40) begin
            step(1'b0, 1'b0);
            n++;
        end
        check("full_reach_mid_burst", (owner == 2 && words == 3), 1);
        winc_cnt = 0;
        repeat (5) step(1'b1, 1'b0);
        check("full_no_winc", winc_cnt, 0);
        n = 0;
        while (owner == 2 && n < 20) begin
            step(1'b0, 1'b0);
            n++;
        end
        check("full_burst_total", dut_words[2], 8);
        clear_reqs();
        repeat (3) step(1'b0, 1'b0);

        // Requester 1 drops after 2 words: grant aborted, requester 2 follows.
        step(1'b0, 1'b1);
        rem[0] = 1;
        use_last[0] = 1'b1;
        repeat (4) step(1'b0, 1'b0);
        clear_counts();
        rem[1] = 2;
        rem[2] = 3;
        use_last[2] = 1'b1;
        repeat (12) step(1'b0, 1'b0);
        check("abort_req1_words", dut_words[1], 2);
        check("abort_req2_words", dut_words[2], 3);
        clear_reqs();

        // Reset on the 4th word of a burst, requester 0 then wins first.
        rem[1] = 20;
        rem[2] = 20;
        n = 0;
        while (!(owner >= 0 && words == 3) && n < 40) begin
            step(1'b0, 1'b0);
            n++;
        end
        check("reset_reach_4th_word", (owner >= 0 && words == 3), 1);
        rem[0] = 20;
        winc_cnt = 0;
        step(1'b0, 1'b1);
        check("reset_mid_burst_winc", winc_cnt, 0);
        step(1'b0, 1'b0);
        check("reset_next_gnt", last_gnt, 0);
        step(1'b0, 1'b0);
        check("reset_first_owner", last_gnt, 4'b0001);
        clear_reqs();
        repeat (3) step(1'b0, 1'b0);

        // Randomized traffic, backpressure, aborts and occasional resets.
        repeat (2000) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rem[i] == 0 && $urandom_range(0, 3) == 0) begin
                    rem[i]      = $urandom_range(1, 12);
                    use_last[i] = 1'($urandom_range(0, 1));
                end else if ($urandom_range(0, 30) == 0) begin
                    rem[i] = 0;
                end
            end
            step($urandom_range(0, 5) == 0, $urandom_range(0, 299) == 0);
        end
        clear_reqs();

`ifdef FIFO_WR_ARB_STATS_EN
        // Enough acks to requester 3 to pass 65535 and saturate.
        step(1'b0, 1'b1);
        acks_total[3] = 0;
        rem[3] = 70000;
        n = 0;
        while (acks_total[3] < 66000 && n < 80000) begin
            step(1'b0, 1'b0);
            n++;
        end
        check("stats_ack_budget", acks_total[3] >= 66000, 1);
        check("stats_sat_req3", wr_count[3*16 +: 16], 16'hFFFF);
        check("stats_req0_zero", wr_count[15:0], 16'h0000);
        clear_reqs();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter DSIZE, default 8: FIFO data width in bits.
REQ-002 Parameter NREQ, default 4: number of write requesters, range 2..8.
REQ-003 Parameter MAX_BURST, default 8: maximum words per grant, range 1..255.
REQ-004 Port wclk, input, 1: the single clock; fifo_wr_arb sits in the FIFO write-clock domain.
REQ-005 Port wrst, input, 1: reset, synchronous and active-high.
REQ-006 Port req, input, NREQ: per-requester word-valid.
REQ-007 Port req_data, input, NREQ*DSIZE: requester i data in bits [i*DSIZE +: DSIZE].
REQ-008 Port req_last, input, NREQ: marks the current word as end of burst.
REQ-009 Port ack, output, NREQ: word accepted from requester i this cycle.
REQ-010 Port gnt, output, NREQ: one-hot current owner, all-zero when no owner.
REQ-011 Port wfull, input, 1: FIFO full flag.
REQ-012 Port winc, output, 1: FIFO write enable.
REQ-013 Port wdata, output, DSIZE: FIFO write data.

Function
REQ-014 The FSM SHALL have two states: IDLE and BURST.
REQ-015 In IDLE with req != 0, the block SHALL register gnt to the first set req bit at or after rr_ptr, searching upward with wrap, and enter BURST the next cycle.
REQ-016 In IDLE with req == 0, the block SHALL hold gnt = 0.
REQ-017 ack[i] SHALL equal gnt[i] & req[i] & !wfull, combinationally.
REQ-018 winc SHALL equal |ack, and wdata SHALL equal the owner's req_data slice, or 0 when gnt == 0.
REQ-019 While wfull = 1, no ack SHALL be issued, and the burst counter and state SHALL hold.
REQ-020 The burst counter SHALL count acks in the current grant.
REQ-021 An ack with req_last = 1, or the ack that makes the count equal MAX_BURST, SHALL end the grant: gnt -> 0 and state -> IDLE on the next edge.
REQ-022 On grant end, rr_ptr SHALL become owner+1 modulo NREQ.
REQ-023 In BURST, if req[owner] = 0 for one cycle, the grant SHALL be aborted exactly as in REQ-021.
REQ-024 One arbitration bubble cycle in IDLE SHALL separate consecutive grants.
REQ-025 Requests from non-owners SHALL be ignored during BURST; no ack SHALL be issued to them.

Reset
REQ-026 On wrst = 1 at a wclk edge, the block SHALL set state = IDLE, gnt = 0, burst counter = 0, rr_ptr = 0, and clear all stats counters.
REQ-027 While wrst = 1, winc, ack and wdata SHALL be 0, including when reset is asserted mid-burst.

Configuration
REQ-028 With macro FIFO_WR_ARB_STATS_EN defined, an output port wr_count, NREQ*16 bits, SHALL exist, holding a saturating 16-bit count of acks per requester.
REQ-029 Without FIFO_WR_ARB_STATS_EN, the wr_count port and its counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 A shared package fifo_wr_arb_pkg SHALL hold the state enum (IDLE, BURST) and the default DSIZE, NREQ and MAX_BURST constants.
REQ-031 The round-robin pick SHALL be a sub-module rr_pick (inputs req and rr_ptr, output one-hot sel), combinational.

Verification
REQ-032 Requester 0 alone sends 3 words, the third with last=1 -> winc high for 3 cycles, gnt0 drops on the next edge, rr_ptr = 1.
REQ-033 All 4 requesters continuously request with MAX_BURST=8 and no last -> owners in order 0,1,2,3,0, 8 words each, 1 idle cycle between grants.
REQ-034 wfull forced high for 5 cycles mid-burst of requester 2 -> no winc in those cycles, burst resumes after, and the total is still 8 words.
REQ-035 Requester 1 drops req after 2 words -> grant aborted and requester 2 granted after the bubble.
REQ-036 wrst asserted on the 4th word of a burst -> next cycle gnt = 0 and winc = 0; after release, requester 0 wins first.
REQ-037 With FIFO_WR_ARB_STATS_EN defined, 70000 acks to requester 3 -> wr_count[3] = 16'hFFFF.
